tag_data_ram: RTL

//  Parametrised tag+data storage array with one-hot wordline addressing; successor to the 16x(4+8) array.

---
 rtl/tag_data_ram_if.sv | 30 +++
 rtl/tag_data_ram.sv | 116 +++++++++++
 2 files changed

// File: rtl/tag_data_ram_if.sv
// Bus between the cache controller and the tag/data array.
// The controller drives the access and flush requests; the array returns registered results and busy.
interface tag_data_ram_if #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8
);
  logic              we;
  logic [DEPTH-1:0]  wl;
  logic              lookup;
  logic              flush;
  logic [TAG_W-1:0]  tag_in;
  logic [DATA_W-1:0] data_in;
  logic [TAG_W-1:0]  tag_out;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              hit;
  logic              busy;
  logic              wl_err;

  modport master (
    output we, wl, lookup, flush, tag_in, data_in,
    input  tag_out, data_out, valid_out, hit, busy, wl_err
  );

  modport slave (
    input  we, wl, lookup, flush, tag_in, data_in,
    output tag_out, data_out, valid_out, hit, busy, wl_err
  );
endinterface

// File: rtl/tag_data_ram.sv
// Tag+data array addressed by a one-hot wordline, with per-row valid bits,
// registered 1-cycle reads, tag-compare hit and a row-by-row flush engine.
module tag_data_ram #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  tag_data_ram_if.slave  bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic [DEPTH-1:0]  valid_reg;
  logic [TAG_W-1:0]  tag_out_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              valid_out_reg;
  logic              hit_reg;
  logic              wl_err_reg;

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              wl_any;
  logic              wl_onehot;
  logic [ADDR_W-1:0] row;
  logic              access;
  logic              wr_en;
  logic              rd_match;

  assign wl_any    = |bus.wl;
  assign wl_onehot = wl_any && ((bus.wl & (bus.wl - DEPTH'(1))) == '0);

  // OR-ing indices is exact when wl is one-hot; other patterns never reach the array.
  always_comb begin
    row = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.wl[i]) begin
        row = row | ADDR_W'(i);
      end
    end
  end

  assign access   = (state_reg == IDLE) && !bus.flush;
  assign wr_en    = access && bus.we && wl_onehot;
  assign rd_match = valid_reg[row] && (tag_mem[row] == bus.tag_in);

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[row]  <= bus.tag_in;
      data_mem[row] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      valid_reg     <= '0;
      tag_out_reg   <= '0;
      data_out_reg  <= '0;
      valid_out_reg <= 1'b0;
      hit_reg       <= 1'b0;
      wl_err_reg    <= 1'b0;
    end else begin
      valid_out_reg <= 1'b0;
      hit_reg       <= 1'b0;
      wl_err_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.flush) begin
            state_reg <= FLUSH;
            cnt_reg   <= '0;
          end else if (wl_onehot) begin
            if (bus.we) begin
              valid_reg[row] <= 1'b1;
              tag_out_reg    <= bus.tag_in;
              data_out_reg   <= bus.data_in;
              valid_out_reg  <= 1'b1;
            end else begin
              tag_out_reg    <= tag_mem[row];
              data_out_reg   <= data_mem[row];
              valid_out_reg  <= valid_reg[row];
              hit_reg        <= bus.lookup && rd_match;
            end
          end else if (wl_any) begin
            wl_err_reg <= 1'b1;
          end
        end
        FLUSH: begin
          valid_reg[cnt_reg] <= 1'b0;
          if (cnt_reg == LAST_ROW) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.tag_out   = tag_out_reg;
  assign bus.data_out  = data_out_reg;
  assign bus.valid_out = valid_out_reg;
  assign bus.hit       = hit_reg;
  assign bus.wl_err    = wl_err_reg;
  assign bus.busy      = (state_reg == FLUSH);
endmodule
